// File: rtl/d_mem_responder.sv
// Word-wide data memory responder with req/ack handshake and range/alignment error checking.
// ack rises WAIT_STATES+1 edges after acceptance; dropping req during the wait aborts the access.
module d_mem_responder #(
    parameter int ADDR_WORDS  = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int          LP_IW    = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam logic [32:0] LP_LIMIT = 33'(ADDR_WORDS) << 2;
    localparam logic [3:0]  LP_WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_mem [ADDR_WORDS];

    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_err;
    logic [LP_IW-1:0] w_idx;
    logic        w_wr_en;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // next-state logic
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_cnt_next = LP_WS;
                    w_next     = (LP_WS != 4'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    w_next     = ST_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // output / control decode
    always_comb begin
        busy         = (r_state != ST_IDLE);
        w_accept     = (r_state == ST_IDLE) && req;
        w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
    end

    // With zero wait states the response is formed on the accepting edge, so the live inputs are used.
    always_comb begin
        w_we    = (r_state == ST_IDLE) ? we    : r_we;
        w_addr  = (r_state == ST_IDLE) ? addr  : r_addr;
        w_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;
        w_be    = (r_state == ST_IDLE) ? be    : r_be;
        w_err   = (w_addr[1:0] != 2'b00) || ({1'b0, w_addr} >= LP_LIMIT);
        w_idx   = w_addr[LP_IW+1:2];
        w_wr_en = w_enter_resp && w_we && !w_err && reset;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_enter_resp) begin
            r_ack   <= 1'b1;
            r_err   <= w_err;
            r_rdata <= (!w_err && !w_we) ? r_mem[w_idx] : 32'h0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;

endmodule

// File: tb/tb_d_mem_responder.sv
// Drives a WAIT_STATES=2 and a WAIT_STATES=0 responder against a word-array reference model.
module tb_d_mem_responder;

    logic        clock;
    logic        rst_n;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  be_s    [2];
    logic [31:0] rdata_s [2];
    logic        ack_s   [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    int          ws_of [2] = '{2, 0};
    logic [31:0] model_mem [2][256];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_ack_cyc = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    d_mem_responder #(.ADDR_WORDS(256), .WAIT_STATES(2)) u_dut_slow (
        .clock(clock), .reset(rst_n),
        .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .be(be_s[0]),
        .rdata(rdata_s[0]), .ack(ack_s[0]), .err(err_s[0]), .busy(busy_s[0])
    );

    d_mem_responder #(.ADDR_WORDS(256), .WAIT_STATES(0)) u_dut_fast (
        .clock(clock), .reset(rst_n),
        .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .be(be_s[1]),
        .rdata(rdata_s[1]), .ack(ack_s[1]), .err(err_s[1]), .busy(busy_s[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a 1 KiB byte space of 256 words; anything misaligned or past the end is an error.
    function automatic void model_txn(input int k, input bit w, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] b,
                                      output bit e, output logic [31:0] rd);
        int idx;
        e  = (a % 4 != 0) || (a >= 32'd1024);
        rd = 32'h0;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[k][idx][8*i +: 8] = d[8*i +: 8];
            end else begin
                rd = model_mem[k][idx];
            end
        end
    endfunction

    // Called between edges with the DUT idle (or in keep mode, right after its previous response).
    task automatic run_txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input bit keep);
        bit          e_exp;
        logic [31:0] rd_exp;
        int          n;
        bit          seen;
        model_txn(k, w, a, d, b, e_exp, rd_exp);
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (ack_s[k]) begin
                seen = 1;
            end else begin
                check("busy_in_wait", 32'(busy_s[k]), 32'd1);
                we_s[k] = 1'($urandom); addr_s[k] = $urandom; wdata_s[k] = $urandom; be_s[k] = 4'($urandom);
            end
        end
        check("ack_latency", 32'(n), 32'(ws_of[k] + 1));
        check("busy_at_ack", 32'(busy_s[k]), 32'd1);
        check("err", 32'(err_s[k]), 32'(e_exp));
        check("rdata", rdata_s[k], rd_exp);
        last_rdata   = rdata_s[k];
        last_err     = err_s[k];
        last_ack_cyc = cyc;
        if (!keep) req_s[k] = 1'b0;
        @(posedge clock); #1;
        check("ack_one_cycle", 32'(ack_s[k]), 32'd0);
        check("busy_after_resp", 32'(busy_s[k]), 32'd0);
    endtask

    function automatic logic [31:0] pick_word();
        int r;
        r = $urandom_range(0, 16);
        return (r == 16) ? 32'd255 * 4 : 32'(r * 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return pick_word();
        if (r < 8) return pick_word() | 32'($urandom_range(1, 3));
        if (r == 8) return 32'h400;
        return 32'h400 | $urandom;
    endfunction

    task automatic check_idle_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check(tag, {29'd0, ack_s[k], err_s[k], busy_s[k]}, 32'd0);
            check(tag, rdata_s[k], 32'h0);
        end
    endtask

    initial begin
        int          prev_ack;
        int          ack_count;
        logic [31:0] a;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0; be_s[k] = '0;
        end

        repeat (2) @(posedge clock);
        #1 check_idle_outputs("reset_state");
        @(negedge clock) rst_n = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
            check_idle_outputs("idle_after_reset");
        end

        // give every word the bench will load a known value
        for (int k = 0; k < 2; k++)
            for (int i = 0; i <= 16; i++)
                run_txn(k, 1'b1, (i == 16) ? 32'h3FC : 32'(i * 4), $urandom, 4'hF, 1'b0);

        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        check("load_after_store", last_rdata, 32'hDEADBEEF);

        run_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
        run_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        check("byte_lanes", last_rdata, 32'h11BB33DD);

        run_txn(0, 1'b1, 32'h24, 32'h55555555, 4'h0, 1'b0);
        run_txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0);
        check("misaligned_err", 32'(last_err), 32'd1);
        run_txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0);
        check("range_err", 32'(last_err), 32'd1);
        run_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        run_txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0);
        check("top_word_ok", 32'(last_err), 32'd0);

        // abort: req dropped while waiting
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h30; wdata_s[0] = 32'hA5A5A5A5; be_s[0] = 4'hF;
        @(posedge clock); #1;
        check("abort_accepted", 32'(busy_s[0]), 32'd1);
        req_s[0] = 1'b0;
        ack_count = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (ack_s[0]) ack_count++;
        end
        check("abort_no_ack", 32'(ack_count), 32'd0);
        check("abort_idle", 32'(busy_s[0]), 32'd0);
        run_txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);

        // reset in the middle of a wait
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h3C; wdata_s[0] = 32'h0BADF00D; be_s[0] = 4'hF;
        @(posedge clock); #1;
        check("rst_accepted", 32'(busy_s[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_mid_wait");
        req_s[0] = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) rst_n = 1'b1;
        ack_count = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (ack_s[0]) ack_count++;
        end
        check("rst_no_ack", 32'(ack_count), 32'd0);
        run_txn(0, 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0);

        // zero wait states, req held high: one accepted request every 2 cycles
        prev_ack = 0;
        for (int i = 0; i < 8; i++) begin
            run_txn(1, 1'b0, pick_word(), 32'h0, 4'h0, (i != 7));
            if (i > 0) check("b2b_spacing", 32'(last_ack_cyc - prev_ack), 32'd2);
            prev_ack = last_ack_cyc;
        end

        for (int i = 0; i < 120; i++) begin
            a = rand_addr();
            run_txn(i % 2, 1'($urandom), a, $urandom, 4'($urandom), 1'b0);
        end

        for (int k = 0; k < 2; k++)
            for (int i = 0; i <= 16; i++)
                run_txn(k, 1'b0, (i == 16) ? 32'h3FC : 32'(i * 4), 32'h0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
